// File: rtl/seq_unsigned_multiplier.sv
// Sequential shift-add unsigned multiplier: one partial product per cycle,
// with a start/done handshake that matches the sequential divider.
module seq_unsigned_multiplier #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic               start,
    output logic [2*WIDTH-1:0] res,
    output logic               done,
    output logic               busy
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE,
        MUL,
        DONE
    } state_t;

    state_t             state, state_nxt;
    logic [WIDTH:0]     acc, acc_nxt;
    logic [WIDTH-1:0]   mcand, mcand_nxt;
    logic [WIDTH-1:0]   mplier, mplier_nxt;
    logic [CW-1:0]      count, count_nxt;
    logic [2*WIDTH-1:0] res_nxt;
    logic               done_nxt;
    logic [WIDTH:0]     sum;
    logic [2*WIDTH:0]   shifted;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            count  <= '0;
            res    <= '0;
            done   <= 1'b0;
        end else begin
            state  <= state_nxt;
            acc    <= acc_nxt;
            mcand  <= mcand_nxt;
            mplier <= mplier_nxt;
            count  <= count_nxt;
            res    <= res_nxt;
            done   <= done_nxt;
        end
    end

    // The accumulator is one bit wider than the multiplicand so the carry of
    // each partial-product add survives the shift into the product.
    always_comb begin
        state_nxt  = state;
        acc_nxt    = acc;
        mcand_nxt  = mcand;
        mplier_nxt = mplier;
        count_nxt  = count;
        res_nxt    = res;
        done_nxt   = 1'b0;
        sum        = acc + (mplier[0] ? {1'b0, mcand} : '0);
        shifted    = {sum, mplier} >> 1;

        case (state)
            IDLE: begin
                if (start) begin
                    if (a == '0 || b == '0) begin
                        res_nxt   = '0;
                        done_nxt  = 1'b1;
                        state_nxt = DONE;
                    end else begin
                        mcand_nxt  = a;
                        mplier_nxt = b;
                        acc_nxt    = '0;
                        count_nxt  = CW'(WIDTH);
                        state_nxt  = MUL;
                    end
                end
            end
            MUL: begin
                acc_nxt    = shifted[2*WIDTH:WIDTH];
                mplier_nxt = shifted[WIDTH-1:0];
                count_nxt  = count - CW'(1);
                if (count == CW'(1)) begin
                    res_nxt   = shifted[2*WIDTH-1:0];
                    done_nxt  = 1'b1;
                    state_nxt = DONE;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_seq_unsigned_multiplier.sv
// Bench for seq_unsigned_multiplier: a latency/product model checked every
// cycle, plus directed cases with hand-computed products and timing.
module tb_seq_unsigned_multiplier;

    localparam int W = 8;

    logic           clk;
    logic           rst_n;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic           start;
    logic [2*W-1:0] res;
    logic           done;
    logic           busy;

    int vectors     = 0;
    int miscompares = 0;
    bit checkEn     = 0;

    seq_unsigned_multiplier #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .a     (a),
        .b     (b),
        .start (start),
        .res   (res),
        .done  (done),
        .busy  (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Model: an accepted request finishes after W edges (zero operands: at
    // once) and then spends one more edge before a new request is taken.
    int             pending = 0;
    logic [2*W-1:0] expRes  = '0;
    logic [2*W-1:0] prod    = '0;
    logic           expDone = 1'b0;
    wire            expBusy = (pending != 0);

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending <= 0;
            expRes  <= '0;
            expDone <= 1'b0;
        end else begin
            expDone <= 1'b0;
            if (pending == 0) begin
                if (start) begin
                    if (a == 0 || b == 0) begin
                        expRes  <= '0;
                        expDone <= 1'b1;
                        pending <= 1;
                    end else begin
                        prod    <= (2*W)'(a) * (2*W)'(b);
                        pending <= W + 1;
                    end
                end
            end else begin
                pending <= pending - 1;
                if (pending == 2) begin
                    expRes  <= prod;
                    expDone <= 1'b1;
                end
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one request at a falling edge; returns just after the accepting edge.
    task automatic applyStimulus(input logic [W-1:0] av, input logic [W-1:0] bv);
        a     = av;
        b     = bv;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic waitDone(input int n0, output int n);
        n = n0;
        while (done !== 1'b1 && n < n0 + 40) begin
            @(negedge clk);
            n++;
        end
        if (done !== 1'b1) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL done_timeout: got no done, expected one within 40 cycles");
        end
    endtask

    typedef struct {
        logic [W-1:0]   x;
        logic [W-1:0]   y;
        logic [2*W-1:0] p;
    } vec_t;

    vec_t table1[3] = '{'{8'd255, 8'd255, 16'hFE01},
                        '{8'd1,   8'd1,   16'h0001},
                        '{8'd128, 8'd2,   16'h0100}};

    initial begin
        int n;
        int extra;
        logic [W-1:0] av, bv;

        rst_n = 1'b0;
        start = 1'b0;
        a     = '0;
        b     = '0;

        fork
            forever begin
                @(negedge clk);
                if (checkEn) begin
                    checkOutput("cyc_done", done, expDone);
                    checkOutput("cyc_busy", busy, expBusy);
                    checkOutput("cyc_res",  res,  expRes);
                end
            end
        join_none

        repeat (2) @(negedge clk);
        checkOutput("reset_res",  res,  0);
        checkOutput("reset_done", done, 0);
        checkOutput("reset_busy", busy, 0);
        checkEn = 1;
        #2 rst_n = 1'b1;
        @(negedge clk);

        $display("[TB] 200 x 150 with latency");
        applyStimulus(8'd200, 8'd150);
        checkOutput("t1_busy", busy, 1);
        waitDone(0, n);
        checkOutput("t1_latency", n, W);
        checkOutput("t1_res", res, 16'h7530);
        checkOutput("t1_model", expRes, 16'h7530);
        @(negedge clk);
        checkOutput("t1_done_fall", done, 0);
        checkOutput("t1_busy_fall", busy, 0);

        $display("[TB] carry and edge operands");
        foreach (table1[i]) begin
            applyStimulus(table1[i].x, table1[i].y);
            waitDone(0, n);
            checkOutput("t2_latency", n, W);
            checkOutput("t2_res", res, table1[i].p);
            @(negedge clk);
        end

        $display("[TB] zero shortcut");
        for (int i = 0; i < 2; i++) begin
            applyStimulus(i == 0 ? 8'd0 : 8'd77, i == 0 ? 8'd77 : 8'd0);
            checkOutput("t3_busy", busy, 1);
            waitDone(0, n);
            checkOutput("t3_latency", n, 0);
            checkOutput("t3_res", res, 0);
            @(negedge clk);
            checkOutput("t3_busy_fall", busy, 0);
            applyStimulus(8'd3, 8'd3);
            waitDone(0, n);
            checkOutput("t3_refill", res, 16'h0009);
            @(negedge clk);
        end

        $display("[TB] start while busy is ignored");
        applyStimulus(8'd13, 8'd11);
        @(negedge clk);
        a     = 8'd99;
        b     = 8'd99;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        waitDone(2, n);
        checkOutput("t4_latency", n, W);
        checkOutput("t4_res", res, 16'h008F);
        extra = 0;
        repeat (14) begin
            @(negedge clk);
            if (done) extra++;
        end
        checkOutput("t4_no_second_done", extra, 0);
        checkOutput("t4_res_held", res, 16'h008F);

        $display("[TB] asynchronous reset mid-operation");
        applyStimulus(8'd200, 8'd150);
        repeat (4) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("t5_res", res, 0);
        checkOutput("t5_done", done, 0);
        checkOutput("t5_busy", busy, 0);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        extra = 0;
        repeat (12) begin
            @(negedge clk);
            if (done) extra++;
        end
        checkOutput("t5_no_done", extra, 0);
        applyStimulus(8'd3, 8'd5);
        waitDone(0, n);
        checkOutput("t5_latency", n, W);
        checkOutput("t5_res_after", res, 16'h000F);
        @(negedge clk);

        $display("[TB] back-to-back with start held");
        a     = 8'd10;
        b     = 8'd20;
        start = 1'b1;
        @(negedge clk);
        a = 8'd7;
        b = 8'd6;
        waitDone(0, n);
        checkOutput("t6_first_latency", n, W);
        checkOutput("t6_first_res", res, 16'h00C8);
        @(negedge clk);
        waitDone(n + 1, n);
        checkOutput("t6_second_done_cycle", n, 2 * W + 2);
        checkOutput("t6_second_res", res, 16'h002A);
        start = 1'b0;
        @(negedge clk);

        $display("[TB] randomized operands");
        for (int i = 0; i < 1000; i++) begin
            av = W'($urandom_range(0, 255));
            bv = W'($urandom_range(0, 255));
            if ($urandom_range(0, 15) == 0) av = '0;
            if ($urandom_range(0, 15) == 0) bv = '0;
            applyStimulus(av, bv);
            a = W'($urandom);
            b = W'($urandom);
            waitDone(0, n);
            checkOutput("rand_latency", n, (av == 0 || bv == 0) ? 0 : W);
            checkOutput("rand_res", res, (2*W)'(av) * (2*W)'(bv));
            @(negedge clk);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        checkEn = 0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
